// File: rtl/not_not_answer_judge.sv
// Answer judge for a NotNot round: waits for the player's first new press against the
// latched colour mask, enforces a per-round timeout, and keeps score, lives and game-over.
module not_not_answer_judge #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SCORE_WIDTH    = 8,
  parameter int START_LIVES    = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   round_start,
  input  logic [3:0]             expected,
  input  logic [3:0]             player_in,
  output logic                   round_busy,
  output logic                   result_valid,
  output logic                   result_correct,
  output logic                   result_timeout,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [1:0]             lives,
  output logic                   game_over
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESULT, OVER} state_t;

  state_t        state;
  logic [3:0]    exp_q;
  logic [3:0]    prev_q;
  logic [TW-1:0] timer;
  logic [3:0]    press_edge;

  // Only buttons that go from released to pressed during the round count as an answer.
  assign press_edge = player_in & ~prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      exp_q          <= '0;
      prev_q         <= '0;
      timer          <= '0;
      round_busy     <= 1'b0;
      result_valid   <= 1'b0;
      result_correct <= 1'b0;
      result_timeout <= 1'b0;
      score          <= '0;
      lives          <= 2'(START_LIVES);
      game_over      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (round_start) begin
            exp_q      <= expected;
            prev_q     <= player_in;
            timer      <= '0;
            round_busy <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          prev_q <= player_in;
          if (press_edge != 4'b0000) begin
            // A multi-press is judged as a set: every new colour must be acceptable.
            result_correct <= ((press_edge & ~exp_q) == 4'b0000);
            result_timeout <= 1'b0;
            result_valid   <= 1'b1;
            round_busy     <= 1'b0;
            state          <= RESULT;
          end else if (timer == TIMER_LAST) begin
            result_correct <= (exp_q == 4'b0000);
            result_timeout <= 1'b1;
            result_valid   <= 1'b1;
            round_busy     <= 1'b0;
            state          <= RESULT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESULT: begin
          result_valid <= 1'b0;
          if (result_correct) begin
            if (score != '1) score <= score + SCORE_WIDTH'(1);
            state <= IDLE;
          end else begin
            lives <= lives - 2'd1;
            if (lives == 2'd1) begin
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              state <= IDLE;
            end
          end
        end
        OVER: begin
          state <= OVER;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
